// File: rtl/lut_sweep_pkg.sv
// rtl/lut_sweep_pkg.sv - shared state encoding and default input width for the LUT sweeper
package lut_sweep_pkg;

    localparam int N_DEFAULT = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/lut_table.sv
// rtl/lut_table.sv - shift-loadable 2^N-bit truth table with a combinational read port
module lut_table
    import lut_sweep_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         shift_en_i,
    input  logic         shift_bit_i,
    input  logic [N-1:0] rd_idx_i,
    output logic         rd_bit_o
);

    localparam int DEPTH = 1 << N;

    logic [DEPTH-1:0] tbl_q;
    logic [DEPTH-1:0] tbl_d;

    // New bits enter at the MSB, so the first bit written ends up at index 0.
    always_comb begin
        tbl_d = tbl_q;
        if (shift_en_i) begin
            tbl_d = {shift_bit_i, tbl_q[DEPTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl_q <= '0;
        end else begin
            tbl_q <= tbl_d;
        end
    end

    assign rd_bit_o = tbl_q[rd_idx_i];

endmodule

// File: rtl/lut_sweep.sv
// rtl/lut_sweep.sv - truth-table evaluator with single-shot lookup and exhaustive input sweep
module lut_sweep
    import lut_sweep_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_we,
    input  logic         cfg_bit,
    input  logic         pos_mode,
    input  logic         eval_vld,
    input  logic [N-1:0] eval_in,
    input  logic         start,
    output logic         s,
    output logic         s_vld,
    output logic [N-1:0] s_idx,
    output logic         busy,
    output logic         done,
    output logic [N:0]   ones_cnt
);

    localparam logic [N-1:0] LAST_IDX = '1;

    state_e       state_q;
    logic         mode_q;
    logic         s_q;
    logic         s_vld_q;
    logic [N-1:0] idx_q;
    logic         busy_q;
    logic         done_q;
    logic [N:0]   ones_q;

    logic         in_idle;
    logic         shift_en;
    logic [N-1:0] rd_idx;
    logic         rd_bit;
    logic         f_live;
    logic         f_sweep;

    assign in_idle  = (state_q == ST_IDLE);
    // start wins over cfg_we; a concurrent eval reads the pre-shift table.
    assign shift_en = in_idle && cfg_we && !start;

    always_comb begin
        rd_idx = eval_in;
        if (state_q == ST_SWEEP) begin
            rd_idx = idx_q + 1'b1;
        end else if (start) begin
            rd_idx = '0;
        end
    end

    lut_table #(.N(N)) u_table (
        .clk         (clk),
        .rst_n       (rst_n),
        .shift_en_i  (shift_en),
        .shift_bit_i (cfg_bit),
        .rd_idx_i    (rd_idx),
        .rd_bit_o    (rd_bit)
    );

    assign f_live  = rd_bit ^ pos_mode;
    assign f_sweep = rd_bit ^ mode_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= 1'b0;
            s_q     <= 1'b0;
            s_vld_q <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ones_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    s_vld_q <= 1'b0;
                    done_q  <= 1'b0;
                    if (start) begin
                        // Index 0 is emitted on the start edge so results begin the next cycle.
                        state_q <= ST_SWEEP;
                        mode_q  <= pos_mode;
                        busy_q  <= 1'b1;
                        s_q     <= f_live;
                        s_vld_q <= 1'b1;
                        idx_q   <= '0;
                        ones_q  <= (N+1)'(f_live);
                    end else if (eval_vld) begin
                        s_q     <= f_live;
                        s_vld_q <= 1'b1;
                        idx_q   <= eval_in;
                    end
                end
                ST_SWEEP: begin
                    if (idx_q == LAST_IDX) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        s_vld_q <= 1'b0;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        s_q     <= f_sweep;
                        s_vld_q <= 1'b1;
                        ones_q  <= ones_q + (N+1)'(f_sweep);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign s        = s_q;
    assign s_vld    = s_vld_q;
    assign s_idx    = idx_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign ones_cnt = ones_q;

endmodule
